seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  4-digit time-multiplexed scanner feeding the binary-to-7-segment decoder.
//  Holds a 16-bit value, selects one nibble per dwell period onto bin[3:0] and
//  drives the matching active-low anode. The downstream decoder turns bin into
//  segments combinationally. New values are committed only at frame boundaries,
//  so the display never tears.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles per digit dwell; legal range >= 2
//  DIV_W        16     prescaler width; must satisfy 2**DIV_W >= REFRESH_DIV
// PORTS
//  clk      in   1   system clock, rising edge
//  rst      in   1   asynchronous, active-high reset
//  load     in   1   1-cycle strobe: capture value/dp_in into shadow register
//  value    in   16  digits [15:12]=d3 .. [3:0]=d0 (d0 = rightmost)
//  dp_in    in   4   decimal-point request per digit, active-high
//  blank_lz in   1   1 = blank leading-zero digits (d0 never blanked)
//  bin      out  4   nibble to the 7-seg decoder for the active digit
//  an       out  4   anode enables, active-low, one-hot-low when lit
//  dp       out  1   decimal point, active-low
//  frame    out  1   1-cycle pulse when d3 dwell ends (frame boundary)
// BEHAVIOUR
//  Reset (async assert, sync release): an=4'b1111, bin=4'h0, dp=1, frame=0,
//   prescaler=0, idx=0, disp=0, disp_dp=0, shadow=0, shadow_dp=0, pending=0.
//  Prescaler counts 0..REFRESH_DIV-1 and wraps; tick=1 at count REFRESH_DIV-1.
//  On tick: idx <= idx+1 mod 4 (scan order d0,d1,d2,d3,d0...).
//  All outputs are registered from the (disp, idx) state, so they change 1 clk
//   after idx changes; the first lit digit after reset is d0, one clk after release.
//  Digit k lit: an[k]=0, others 1; bin=disp[4k+3:4k]; dp=~disp_dp[k].
//  Leading-zero blank: if blank_lz and k>0 and disp[15:4k]==0, an=4'b1111,
//   dp=1, bin=disp nibble (don't-care). blank_lz is sampled live, not shadowed.
//  load: shadow<=value, shadow_dp<=dp_in, pending<=1. The last load wins.
//  Commit: on tick with idx==3, frame pulses; if pending, disp<=shadow,
//   disp_dp<=shadow_dp, pending<=0. The new value shows from d0 of the next frame.
//  Load and commit in the same cycle: commit takes the pre-load shadow; the
//   shadow then takes the new value and pending stays 1 (it commits next frame).
//  Load held high for several cycles: each cycle recaptures (level-tolerant).
//  No load ever: display holds its last committed value indefinitely.
//  Reset mid-frame: everything returns to reset values immediately; pending
//   loads are discarded.
// STRUCTURE
//  Package seg7_pkg: N_DIGITS=4, NIBBLE_W=4, AN_OFF=4'b1111, idx typedef
//   logic [1:0] digit_idx_t.
//  Sub-module seg7_tick_gen #(REFRESH_DIV, DIV_W) (clk, rst, tick): prescaler only.
//  Top: idx counter, shadow/pending/disp registers, blank logic, output regs.
// TESTING (bench uses REFRESH_DIV=4)
//  1 Assert rst mid-run -> an=1111, dp=1, bin=0, frame=0 immediately; after
//    release, an=1110 with bin=0 one clk later.
//  2 load 16'h1234, dp_in=4'b0100, blank_lz=0 -> after the next frame pulse, scan
//    shows an/bin 1110/4,1101/3,1011/2,0111/1 for 4 clks each; dp=0 only at d2.
//  3 Commit 16'h0042 with blank_lz=1 -> d0=2, d1=4 lit; d2,d3 an=1111; then
//    16'h0000 -> only d0 lit, bin=0.
//  4 load 16'hAAAA mid-frame -> no change until the frame pulse; d0 of the next
//    frame shows bin=A.
//  5 load 16'h5555 in the same cycle as a commit of pending 16'h1111 -> next frame
//    shows 1111, pending=1, and the frame after shows 5555.
//  6 Two loads (16'hBEEF then 16'hCAFE) within one frame -> only CAFE displayed;
//    frame pulses every 16 clks exactly.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scanner.
// Also holds the leading-zero test used by the blanking logic.
package seg7_pkg;

   localparam int         N_DIGITS = 4;
   localparam int         NIBBLE_W = 4;
   localparam logic [3:0] AN_OFF   = 4'b1111;

   typedef logic [1:0] digit_idx_t;

   // True when every digit at or above position k is zero (k=0 never blanks)
   function automatic logic lead_zero(input logic [15:0] v,
                                      input digit_idx_t  k);
      logic r;
      unique case (k)
         2'd0: r = 1'b0;
         2'd1: r = (v[15:4] == 12'h000);
         2'd2: r = (v[15:8] == 8'h00);
         2'd3: r = (v[15:12] == 4'h0);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Load/display bundle between a value producer and the digit scanner.
// master drives the value side, slave is the scanner.
interface seg7_scan_mux_if;

   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  bin;
   logic [3:0]  an;
   logic        dp;
   logic        frame;

   modport master (
      output load, value, dp_in, blank_lz,
      input  bin, an, dp, frame
   );

   modport slave (
      input  load, value, dp_in, blank_lz,
      output bin, an, dp, frame
   );

endinterface

// File: rtl/seg7_tick_gen.sv
// Digit-dwell prescaler: counts 0..REFRESH_DIV-1 and wraps.
// tick is high during the last count of each dwell.
module seg7_tick_gen #(
   parameter int REFRESH_DIV = 50000,
   parameter int DIV_W       = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == DIV_W'(REFRESH_DIV - 1));
   assign tick   = w_last;

   // Free-running dwell counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// 4-digit time-multiplexed scanner with frame-synchronous value commit.
// Outputs are registered from (disp, idx), one clk behind the scan index.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int DIV_W       = 16
) (
   input  logic           clk,
   input  logic           rst,
   seg7_scan_mux_if.slave bus
);

   logic        w_tick;
   logic        w_commit;
   logic        w_blank;
   logic [3:0]  w_nib;
   logic [3:0]  w_an_lit;

   digit_idx_t  r_idx;
   logic [15:0] r_disp;
   logic [3:0]  r_disp_dp;
   logic [15:0] r_shadow;
   logic [3:0]  r_shadow_dp;
   logic        r_pending;
   logic [3:0]  r_an;
   logic [3:0]  r_bin;
   logic        r_dp;
   logic        r_frame;

   seg7_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV),
      .DIV_W       (DIV_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign w_commit = w_tick && (r_idx == digit_idx_t'(N_DIGITS - 1));
   assign w_blank  = bus.blank_lz && lead_zero(r_disp, r_idx);
   assign w_nib    = r_disp[{r_idx, 2'b00} +: NIBBLE_W];
   assign w_an_lit = ~(4'b0001 << r_idx);

   // Scan index advances once per dwell
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if (w_tick) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   // Shadow capture and frame-boundary commit; a load in the
   // commit cycle lands in the shadow and stays pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_disp      <= '0;
         r_disp_dp   <= '0;
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_pending   <= 1'b0;
      end else begin
         if (w_commit && r_pending) begin
            r_disp    <= r_shadow;
            r_disp_dp <= r_shadow_dp;
            r_pending <= 1'b0;
         end
         if (bus.load) begin
            r_shadow    <= bus.value;
            r_shadow_dp <= bus.dp_in;
            r_pending   <= 1'b1;
         end
      end
   end

   // Registered display outputs for the current digit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an    <= AN_OFF;
         r_bin   <= '0;
         r_dp    <= 1'b1;
         r_frame <= 1'b0;
      end else begin
         r_bin   <= w_nib;
         r_frame <= w_commit;
         if (w_blank) begin
            r_an <= AN_OFF;
            r_dp <= 1'b1;
         end else begin
            r_an <= w_an_lit;
            r_dp <= ~r_disp_dp[r_idx];
         end
      end
   end

   assign bus.an    = r_an;
   assign bus.bin   = r_bin;
   assign bus.dp    = r_dp;
   assign bus.frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized + directed bench for seg7_scan_mux against a cycle-count model.
// Scan position and frame timing are derived arithmetically from cycles since reset.
module tb_seg7_scan_mux;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic clk;
   logic rst;

   seg7_scan_mux_if b ();

   seg7_scan_mux #(
      .REFRESH_DIV (DIV),
      .DIV_W       (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec;
   int          n_err;
   int          c;
   logic [15:0] m_disp;
   logic [3:0]  m_dp;
   logic [15:0] m_sh;
   logic [3:0]  m_shdp;
   bit          m_pend;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp_v, c);
      end
   endtask

   task automatic model_reset();
      m_disp = '0;
      m_dp   = '0;
      m_sh   = '0;
      m_shdp = '0;
      m_pend = 1'b0;
      c      = 0;
   endtask

   // One clock: predict outputs from pre-edge model state, advance model, check
   task automatic step();
      int         k;
      logic       bl;
      logic       e_fr;
      logic       e_dp;
      logic [3:0] e_an;
      logic [3:0] e_bin;
      k     = (c / DIV) % 4;
      e_fr  = ((c % FRAME) == FRAME - 1);
      bl    = b.blank_lz && (k > 0) && ((m_disp >> (4 * k)) == 16'h0);
      e_an  = bl ? 4'hF : ~(4'b0001 << k);
      e_bin = m_disp[4*k +: 4];
      e_dp  = bl ? 1'b1 : ~m_dp[k];
      if (e_fr && m_pend) begin
         m_disp = m_sh;
         m_dp   = m_shdp;
         m_pend = 1'b0;
      end
      if (b.load) begin
         m_sh   = b.value;
         m_shdp = b.dp_in;
         m_pend = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("an", 16'(b.an), 16'(e_an));
      chk("dp", 16'(b.dp), 16'(e_dp));
      chk("frame", 16'(b.frame), 16'(e_fr));
      if (!bl) chk("bin", 16'(b.bin), 16'(e_bin));
      c++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int ph);
      while ((c % FRAME) != ph) step();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      b.value = v;
      b.dp_in = d;
      b.load  = 1'b1;
      step();
      b.load  = 1'b0;
   endtask

   // Asynchronous reset between edges, held across one edge
   task automatic rst_pulse();
      #2;
      rst    = 1'b1;
      b.load = 1'b0;
      #1;
      chk("rst_an", 16'(b.an), 16'hF);
      chk("rst_bin", 16'(b.bin), 16'h0);
      chk("rst_dp", 16'(b.dp), 16'h1);
      chk("rst_frame", 16'(b.frame), 16'h0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_hold_an", 16'(b.an), 16'hF);
      rst = 1'b0;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b0;
      b.load     = 1'b0;
      b.value    = '0;
      b.dp_in    = '0;
      b.blank_lz = 1'b0;
      model_reset();
      #1;
      rst_pulse();
      run(3);

      do_load(16'h1234, 4'b0100);
      run(40);

      b.blank_lz = 1'b1;
      do_load(16'h0042, 4'b0000);
      run(36);
      do_load(16'h0000, 4'b0000);
      run(36);

      b.blank_lz = 1'b0;
      run_to(6);
      do_load(16'hAAAA, 4'b0000);
      run(32);

      run_to(3);
      do_load(16'h1111, 4'b0001);
      run_to(15);
      do_load(16'h5555, 4'b1000);
      run(40);

      run_to(2);
      do_load(16'hBEEF, 4'b0000);
      run(5);
      do_load(16'hCAFE, 4'b0010);
      run(40);

      do_load(16'h0100, 4'b0000);
      do_load(16'h0200, 4'b0000);
      do_load(16'h0300, 4'b0100);
      run(36);

      do_load(16'h7777, 4'b1111);
      run(3);
      rst_pulse();
      run(40);

      for (int i = 0; i < 3000; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         case ($urandom % 4)
            0: v = v & 16'h00FF;
            1: v = v & 16'h000F;
            2: v = v & 16'h0FFF;
            default: ;
         endcase
         if (($urandom % 32) == 0) b.blank_lz = ~b.blank_lz;
         b.load  = (($urandom % 8) == 0);
         b.value = v;
         b.dp_in = 4'($urandom);
         step();
         b.load = 1'b0;
         if (($urandom % 700) == 0) rst_pulse();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
